// File: rtl/l2_pkg.sv
// Shared layer-2 frame constants. The forwarding core and the transmitters
// import the same package, so the field layout is defined in exactly one place.
package l2_pkg;

  // Frame geometry
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int SFD_WIDTH  = 4;

  localparam logic [SFD_WIDTH-1:0]  SFD_PATTERN    = 4'b1011;
  localparam logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = '1;

  // Field positions, MSB of the frame is the first bit on the wire
  localparam int SFD_MSB     = DEPTH - 1;
  localparam int SFD_LSB     = DEPTH - SFD_WIDTH;
  localparam int DEST_MSB    = SFD_LSB - 1;
  localparam int DEST_LSB    = DEST_MSB - ADDR_WIDTH + 1;
  localparam int SRC_MSB     = DEST_LSB - 1;
  localparam int SRC_LSB     = SRC_MSB - ADDR_WIDTH + 1;
  localparam int PAYLOAD_MSB = SRC_LSB - 1;
  localparam int PAYLOAD_LSB = 0;

  // Counter wide enough to hold the number of post-SFD bits
  localparam int BIT_CNT_WIDTH = $clog2(DEPTH + 1);

  typedef logic [DEPTH-1:0] frame_t;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  // Extract the source address field from a complete frame
  function automatic logic [ADDR_WIDTH-1:0] frame_src(input frame_t frame);
    return frame[SRC_MSB:SRC_LSB];
  endfunction

  // Extract the destination address field from a complete frame
  function automatic logic [ADDR_WIDTH-1:0] frame_dest(input frame_t frame);
    return frame[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/l2_rx_deframer_if.sv
// Frame handoff from the deframer to the forwarding core: valid/ready with
// the captured frame held stable until accepted.
interface l2_rx_deframer_if;
  import l2_pkg::*;

  frame_t rx_frame;
  logic   frame_valid;
  logic   frame_ready;

  // Producer side (deframer)
  modport master (
    output rx_frame,
    output frame_valid,
    input  frame_ready
  );

  // Consumer side (forwarding core)
  modport slave (
    input  rx_frame,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/l2_sat_counter.sv
// Statistics counter that increments on a one-cycle pulse and holds at its
// maximum value instead of wrapping.
module l2_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count pulses, stick at all-ones
  // NOTE: state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/l2_rx_deframer.sv
// Bit-serial ingress deframer. Hunts for the SFD, shifts in the remainder of
// the frame, and hands completed frames to the forwarding core. Frames with a
// broadcast source, or that arrive while the output slot is still occupied,
// are dropped and counted.
module l2_rx_deframer
  import l2_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  l2_rx_deframer_if.master     frame_if,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] bad_src_cnt,
  output logic [CNT_WIDTH-1:0] overflow_cnt
);

  rx_state_e                state;
  rx_state_e                state_next;
  logic [SFD_WIDTH-1:0]     hunt_reg;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  frame_t                   work_reg;
  frame_t                   new_frame;
  frame_t                   rx_frame_q;
  logic                     frame_valid_q;

  logic sfd_hit;
  logic frame_done;
  logic src_bad;
  logic slot_free;
  logic frame_load;
  logic bad_inc;
  logic ovf_inc;

  // The frame as it stands once the bit on the line this cycle is included
  assign new_frame = {work_reg[DEPTH-2:0], rx_bit};
  assign src_bad   = (frame_src(new_frame) == BROADCAST_ADDR);

  // The slot is free if empty, or if its current frame is taken this edge
  assign slot_free = !frame_valid_q || frame_if.frame_ready;

  // Next-state decode and completion detection
  // NOTE: every output gets a default first so no path leaves it unassigned.
  always_comb begin
    state_next = state;
    sfd_hit    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if ({hunt_reg[SFD_WIDTH-2:0], rx_bit} == SFD_PATTERN) begin
          sfd_hit    = 1'b1;
          state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        if (bit_cnt == BIT_CNT_WIDTH'(1)) begin
          frame_done = 1'b1;
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  // Emit decision, taken at the edge that samples the last bit
  always_comb begin
    frame_load = frame_done && !src_bad && slot_free;
    bad_inc    = frame_done && src_bad;
    ovf_inc    = frame_done && !src_bad && !slot_free;
  end

  // State register; busy is registered from the next-state decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_HUNT;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RECV);
    end
  end

  // Hunt and working shift registers plus the remaining-bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hunt_reg <= '0;
      bit_cnt  <= '0;
      work_reg <= '0;
    end else begin
      unique case (state)
        ST_HUNT: begin
          hunt_reg <= {hunt_reg[SFD_WIDTH-2:0], rx_bit};
          if (sfd_hit) begin
            bit_cnt  <= BIT_CNT_WIDTH'(DEPTH - SFD_WIDTH);
            work_reg <= DEPTH'(SFD_PATTERN);
          end
        end
        ST_RECV: begin
          // Held at zero so payload bits cannot combine with the next
          // frame's leading bits into a false delimiter.
          hunt_reg <= '0;
          work_reg <= new_frame;
          bit_cnt  <= bit_cnt - BIT_CNT_WIDTH'(1);
        end
        default: begin
          hunt_reg <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Output slot: load a good frame, or clear once the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_frame_q    <= '0;
      frame_valid_q <= 1'b0;
    end else if (frame_load) begin
      rx_frame_q    <= new_frame;
      frame_valid_q <= 1'b1;
    end else if (frame_valid_q && frame_if.frame_ready) begin
      frame_valid_q <= 1'b0;
    end
  end

  assign frame_if.rx_frame    = rx_frame_q;
  assign frame_if.frame_valid = frame_valid_q;

  l2_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_bad_src_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bad_inc),
    .count (bad_src_cnt)
  );

  l2_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_overflow_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovf_inc),
    .count (overflow_cnt)
  );

endmodule

// File: tb/tb_l2_rx_deframer.sv
// Self-checking bench for l2_rx_deframer. The stimulus side builds aligned
// frames, predicts each frame's fate from the drop/accept rules and queues the
// accepted ones; an independent monitor compares whatever the DUT presents.
module tb_l2_rx_deframer;
  import l2_pkg::*;

  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       busy;
  logic [7:0] bad_src_cnt;
  logic [7:0] overflow_cnt;

  l2_rx_deframer_if frame_if ();

  l2_rx_deframer #(
    .CNT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_bit       (rx_bit),
    .frame_if     (frame_if),
    .busy         (busy),
    .bad_src_cnt  (bad_src_cnt),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DEPTH-1:0] frame;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   m_valid = 1'b0;
  int   exp_bad = 0;
  int   exp_ovf = 0;
  int   ready_pct = 100;
  bit   mon_fresh = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour for the coming edge. The stimulus knows where each
  // frame ends, so the model only applies the drop/accept/handshake rules.
  function automatic void model_edge(input bit complete, input logic [DEPTH-1:0] f, input bit rdy);
    bit handshake;
    handshake = m_valid && rdy;
    if (complete) begin
      if (f[SRC_MSB:SRC_LSB] == BROADCAST_ADDR) begin
        if (exp_bad < CNT_MAX) exp_bad++;
        if (handshake) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        exp_q.push_back('{frame: f, due: cyc + 1});
        m_valid = 1'b1;
      end else begin
        if (exp_ovf < CNT_MAX) exp_ovf++;
      end
    end else if (handshake) begin
      m_valid = 1'b0;
    end
  endfunction

  // Drive one line bit and a consumer ready, then step to just past the edge
  task automatic drive_bit(input logic b, input bit complete, input logic [DEPTH-1:0] f);
    rx_bit = b;
    frame_if.frame_ready = ($urandom_range(0, 99) < ready_pct);
    model_edge(complete, f, frame_if.frame_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DEPTH-1:0] f);
    for (int i = DEPTH - 1; i >= 0; i--) drive_bit(f[i], (i == 0), f);
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) drive_bit(b, 1'b0, '0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_bad_src_cnt"}, bad_src_cnt, exp_bad);
    check({tag, "_overflow_cnt"}, overflow_cnt, exp_ovf);
  endtask

  function automatic logic [DEPTH-1:0] rand_frame();
    logic [ADDR_WIDTH-1:0] src;
    src = ($urandom_range(0, 3) == 0) ? BROADCAST_ADDR : ADDR_WIDTH'($urandom);
    return {SFD_PATTERN, ADDR_WIDTH'($urandom), src, (DEPTH - SFD_WIDTH - 2 * ADDR_WIDTH)'($urandom)};
  endfunction

  // Monitor: compares every frame the DUT presents against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      mon_fresh = 1'b1;
    end else if (frame_if.frame_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", frame_if.frame_valid, 1'b0);
      end else begin
        if (mon_fresh) begin
          check("latency", cyc, exp_q[0].due);
          check("frame_data", frame_if.rx_frame, exp_q[0].frame);
          mon_fresh = 1'b0;
        end
        if (frame_if.frame_ready) begin
          check("frame_at_accept", frame_if.rx_frame, exp_q[0].frame);
          void'(exp_q.pop_front());
          mon_fresh = 1'b1;
        end
      end
    end else if (!mon_fresh) begin
      check("valid_dropped", frame_if.frame_valid, 1'b1);
      mon_fresh = 1'b1;
    end
  end

  initial begin
    logic [DEPTH-1:0] f;
    rst = 1'b0;
    rx_bit = 1'b0;
    frame_if.frame_ready = 1'b0;
    #12;
    check("rst_frame_valid", frame_if.frame_valid, 1'b0);
    check("rst_rx_frame", frame_if.rx_frame, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check_counters("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single frame, consumer always ready
    ready_pct = 100;
    idle(4, 1'b0);
    send_frame(16'hB215);
    check("single_valid_after_last", frame_if.frame_valid, 1'b1);
    idle(1, 1'b0);
    check("single_valid_one_cycle", frame_if.frame_valid, 1'b0);
    check_counters("single");

    // Backpressure hold
    ready_pct = 0;
    send_frame(16'hB3A7);
    for (int i = 0; i < 20; i++) begin
      idle(1, 1'b0);
      check("hold_valid", frame_if.frame_valid, 1'b1);
      check("hold_data", frame_if.rx_frame, 16'hB3A7);
    end
    ready_pct = 100;
    idle(1, 1'b0);
    check("hold_release", frame_if.frame_valid, 1'b0);

    // Overflow and saturation
    ready_pct = 0;
    send_frame(16'hB3A7);
    send_frame(16'hB4C1);
    check("ovf_first", overflow_cnt, 8'd1);
    check("ovf_kept_old", frame_if.rx_frame, 16'hB3A7);
    for (int i = 0; i < 300; i++) send_frame(16'hB4C1);
    check("ovf_saturated", overflow_cnt, 8'd255);
    check_counters("ovf");
    ready_pct = 100;
    idle(3, 1'b0);

    // Broadcast source dropped, following frame accepted
    send_frame(16'hB2F9);
    check("bad_src_first", bad_src_cnt, 8'd1);
    send_frame(16'hB215);
    idle(2, 1'b0);
    check_counters("bad_src");

    // Zero-gap frames, payload carrying the delimiter pattern
    send_frame(16'hB1BB);
    send_frame(16'hB2B0);
    idle(20, 1'b1);
    check("idle_ones_busy", busy, 1'b0);
    check("zero_gap_drained", exp_q.size(), 0);

    // Reset in the middle of a frame
    idle(2, 1'b0);
    f = 16'hB215;
    for (int i = DEPTH - 1; i >= 8; i--) drive_bit(f[i], 1'b0, f);
    check("mid_frame_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", frame_if.frame_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    m_valid = 1'b0;
    exp_bad = 0;
    exp_ovf = 0;
    check_counters("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2, 1'b0);
    send_frame(16'hB215);
    idle(2, 1'b0);

    // Random frames, gaps of constant idle level, varying consumer readiness
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0:       ready_pct = 100;
        1:       ready_pct = 60;
        default: ready_pct = 15;
      endcase
      idle($urandom_range(0, 4), 1'($urandom));
      send_frame(rand_frame());
      if (n % 25 == 24) check_counters("rand");
    end

    ready_pct = 100;
    idle(4, 1'b0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", frame_if.frame_valid, 1'b0);
    check("final_busy", busy, 1'b0);
    check_counters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
